// File: rtl/dzcpu_useq.sv
// Microcode sequencer for the dzcpu core: fetches an opcode, dispatches through the
// opcode/CB lookup tables and steps a micro-PC through the microcode ROM until end-of-flow.
module dzcpu_useq #(
    parameter int          MAX_FLOW_LEN = 32,
    parameter logic [4:0]  JCB_OP       = 5'h0E
) (
    input  logic        iClock,
    input  logic        iReset,
    output logic        oFetchReq,
    input  logic        iFetchAck,
    input  logic [7:0]  iMemData,
    output logic [7:0]  oMop,
    input  logic [7:0]  iLutIdx,
    input  logic [7:0]  iCbLutIdx,
    output logic [7:0]  oUopAddr,
    input  logic [12:0] iUop,
    input  logic        iZeroFlag,
    input  logic        iStall,
    output logic        oExecValid,
    output logic [8:0]  oExecOp,
    output logic        oPcInc,
    output logic        oFlagsUpdate,
    output logic        oInstrDone,
    output logic        oUcodeErr
);

    localparam int                CNT_W    = (MAX_FLOW_LEN > 2) ? $clog2(MAX_FLOW_LEN) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_FLOW_LEN - 1);

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_FETCH  = 2'd1,
        S_DECODE = 2'd2,
        S_EXEC   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_mop;
    logic [7:0]        r_upc;
    logic              r_cb;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic [3:0]        w_code;
    logic              w_run;
    logic              w_jcb;
    logic              w_end;
    logic              w_zexit;
    logic              w_inc;
    logic              w_fu;
    logic              w_wdog;

    assign w_code  = iUop[12:9];
    assign w_run   = (r_state == S_EXEC) && !iStall;
    assign w_jcb   = (iUop[8:4] == JCB_OP);
    assign w_end   = (w_code == 4'd2) || (w_code == 4'd3) || (w_code == 4'd6) || (w_code == 4'd7);
    assign w_zexit = ((w_code == 4'd4) && iZeroFlag) || ((w_code == 4'd5) && !iZeroFlag);
    assign w_inc   = (w_code == 4'd1) || (w_code == 4'd3) || (w_code == 4'd4) ||
                     (w_code == 4'd5) || (w_code == 4'd7);
    assign w_fu    = (w_code == 4'd6) || (w_code == 4'd7) || (w_code == 4'd8);
    // A CB jump leaves the flow itself, so it never trips the watchdog.
    assign w_wdog  = !w_end && !w_zexit && !w_jcb && (r_cnt == CNT_LAST);

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) r_state <= S_RESET;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        oFetchReq    = 1'b0;
        oExecValid   = 1'b0;
        oPcInc       = 1'b0;
        oFlagsUpdate = 1'b0;
        oInstrDone   = 1'b0;
        case (r_state)
            S_RESET:  w_next = S_FETCH;
            S_FETCH: begin
                oFetchReq = 1'b1;
                if (iFetchAck) w_next = S_DECODE;
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                if (!iStall) begin
                    oExecValid   = !w_zexit;
                    oPcInc       = w_inc;
                    oFlagsUpdate = w_fu;
                    oInstrDone   = !w_jcb && (w_end || w_zexit || w_wdog);
                    if (w_jcb || w_end || w_zexit || w_wdog) w_next = S_FETCH;
                end
            end
            default:  w_next = S_RESET;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            r_mop <= 8'd0;
            r_upc <= 8'd0;
            r_cb  <= 1'b0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if ((r_state == S_FETCH) && iFetchAck) r_mop <= iMemData;
            if (r_state == S_DECODE) begin
                r_upc <= r_cb ? iCbLutIdx : iLutIdx;
                r_cb  <= 1'b0;
                r_cnt <= '0;
            end else if (w_run) begin
                if (w_jcb) begin
                    r_cb <= 1'b1;
                end else if (w_wdog) begin
                    r_err <= 1'b1;
                end else if (!w_end && !w_zexit) begin
                    r_upc <= r_upc + 8'd1;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign oMop      = r_mop;
    assign oUopAddr  = r_upc;
    assign oExecOp   = iUop[8:0];
    assign oUcodeErr = r_err;

endmodule

// File: tb/tb_dzcpu_useq.sv
// Bench for dzcpu_useq: table of single-uop behaviours, directed multi-cycle sequences,
// and random ROM/LUT contents checked against a flow-walking reference model.
module tb_dzcpu_useq;

    localparam int MAXF = 32;

    logic        iClock;
    logic        iReset;
    logic        oFetchReq;
    logic        iFetchAck;
    logic [7:0]  iMemData;
    logic [7:0]  oMop;
    logic [7:0]  iLutIdx;
    logic [7:0]  iCbLutIdx;
    logic [7:0]  oUopAddr;
    logic [12:0] iUop;
    logic        iZeroFlag;
    logic        iStall;
    logic        oExecValid;
    logic [8:0]  oExecOp;
    logic        oPcInc;
    logic        oFlagsUpdate;
    logic        oInstrDone;
    logic        oUcodeErr;

    dzcpu_useq #(.MAX_FLOW_LEN(MAXF), .JCB_OP(5'h0E)) dut (
        .iClock(iClock), .iReset(iReset), .oFetchReq(oFetchReq), .iFetchAck(iFetchAck),
        .iMemData(iMemData), .oMop(oMop), .iLutIdx(iLutIdx), .iCbLutIdx(iCbLutIdx),
        .oUopAddr(oUopAddr), .iUop(iUop), .iZeroFlag(iZeroFlag), .iStall(iStall),
        .oExecValid(oExecValid), .oExecOp(oExecOp), .oPcInc(oPcInc),
        .oFlagsUpdate(oFlagsUpdate), .oInstrDone(oInstrDone), .oUcodeErr(oUcodeErr)
    );

    // Environment: combinational microcode ROM and the two opcode lookup tables.
    logic [12:0] rom   [256];
    logic [7:0]  lut   [256];
    logic [7:0]  cblut [256];
    always_comb iUop      = rom[oUopAddr];
    always_comb iLutIdx   = lut[oMop];
    always_comb iCbLutIdx = cblut[oMop];

    initial iClock = 1'b0;
    always #5 iClock = ~iClock;

    int checks = 0;
    int errors = 0;
    bit exp_err = 1'b0;
    bit cb_next = 1'b0;

    typedef struct {
        logic [7:0] addr;
        bit v, pc, fu, done, wd;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [3:0] code;
        bit z, v, pc, fu, done;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_ctl(input string nm, input bit fr, input bit v, input bit pc,
                           input bit fu, input bit done);
        chk(nm, 32'({oFetchReq, oExecValid, oPcInc, oFlagsUpdate, oInstrDone, oUcodeErr}),
                32'({fr, v, pc, fu, done, exp_err}));
    endtask

    // Entered just after a rising edge with the DUT expected to be in FETCH.
    task automatic fetch(input logic [7:0] b, input int dly);
        @(negedge iClock);
        chk_ctl("fetch_req", 1, 0, 0, 0, 0);
        for (int k = 0; k < dly; k++) begin
            @(posedge iClock); #1;
            @(negedge iClock);
            chk_ctl("fetch_hold", 1, 0, 0, 0, 0);
        end
        iFetchAck = 1'b1;
        iMemData  = b;
        @(posedge iClock); #1;
        iFetchAck = 1'b0;
        iMemData  = 8'($urandom);
        @(negedge iClock);
        chk_ctl("decode", 0, 0, 0, 0, 0);
        chk("mop", 32'(oMop), 32'(b));
        @(posedge iClock); #1;
    endtask

    task automatic exec_cyc(input string nm, input bit st, input logic [7:0] a,
                            input bit v, input bit pc, input bit fu, input bit done);
        iStall = st;
        @(negedge iClock);
        chk_ctl(nm, 0, v, pc, fu, done);
        chk({nm, "_addr"}, 32'(oUopAddr), 32'(a));
        chk({nm, "_op"}, 32'(oExecOp), 32'(rom[a][8:0]));
        @(posedge iClock); #1;
        iStall = 1'b0;
    endtask

    // Reference model: walk the ROM from a flow start, applying the flow-code rules.
    function automatic void build(input logic [7:0] start, input bit z);
        logic [7:0] a;
        logic [3:0] c;
        exp_t r;
        bit zx;
        a = start;
        q.delete();
        cb_next = 1'b0;
        for (int n = 0; n < MAXF; n++) begin
            c      = rom[a][12:9];
            zx     = (c == 4'd4 && z) || (c == 4'd5 && !z);
            r.addr = a;
            r.v    = !zx;
            r.pc   = c inside {4'd1, 4'd3, 4'd4, 4'd5, 4'd7};
            r.fu   = c inside {4'd6, 4'd7, 4'd8};
            r.done = 1'b0;
            r.wd   = 1'b0;
            if (rom[a][8:4] == 5'h0E) begin
                cb_next = 1'b1;
                q.push_back(r);
                return;
            end
            if (zx || (c inside {4'd2, 4'd3, 4'd6, 4'd7})) begin
                r.done = 1'b1;
                q.push_back(r);
                return;
            end
            if (n == MAXF - 1) begin
                r.done = 1'b1;
                r.wd   = 1'b1;
                q.push_back(r);
                return;
            end
            q.push_back(r);
            a = a + 8'd1;
        end
    endfunction

    task automatic run_exec();
        exp_t r;
        while (q.size() > 0) begin
            r = q.pop_front();
            if ($urandom_range(0, 3) == 0) exec_cyc("rnd_stall", 1, r.addr, 0, 0, 0, 0);
            exec_cyc("rnd", 0, r.addr, r.v, r.pc, r.fu, r.done);
            if (r.wd) exp_err = 1'b1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bit         cbp;
        logic [7:0] b;

        for (int a = 0; a < 256; a++) begin
            rom[a]   = {4'd2, 9'h000};
            lut[a]   = 8'd0;
            cblut[a] = 8'd0;
        end
        rom[0]       = {4'd3, 9'h005};
        lut[8'h06]   = 8'd23;
        rom[23]      = {4'd1, 9'h011};
        rom[24]      = {4'd1, 9'h012};
        rom[25]      = {4'd2, 9'h013};
        lut[8'h20]   = 8'd17;
        rom[17]      = {4'd1, 9'h021};
        rom[18]      = {4'd1, 9'h022};
        rom[19]      = {4'd4, 9'h023};
        rom[20]      = {4'd1, 9'h024};
        rom[21]      = {4'd1, 9'h025};
        rom[22]      = {4'd2, 9'h026};
        lut[8'hCB]   = 8'd13;
        rom[13]      = {4'd0, 9'h031};
        rom[14]      = {4'd0, 9'h032};
        rom[15]      = {4'd1, 5'h0E, 4'h0};
        cblut[8'h7C] = 8'd16;
        rom[16]      = {4'd6, 9'h034};
        lut[8'h7C]   = 8'd100;
        rom[100]     = {4'd2, 9'h033};
        lut[8'h80]   = 8'd200;
        for (int a = 200; a < 232; a++) rom[a] = {4'd0, 9'h001};
        lut[8'h40]   = 8'd40;

        tbl[0]  = '{4'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4'd1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{4'd2,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{4'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{4'd4,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{4'd4,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{4'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{4'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[8]  = '{4'd6,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{4'd7,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tbl[10] = '{4'd8,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{4'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        iReset    = 1'b0;
        iFetchAck = 1'b1;
        iMemData  = 8'hAA;
        iZeroFlag = 1'b0;
        iStall    = 1'b0;

        // Reset held for three cycles, then one RESET cycle before fetching.
        for (int k = 0; k < 3; k++) begin
            @(negedge iClock);
            chk_ctl("rst", 0, 0, 0, 0, 0);
            chk("rst_mop", 32'(oMop), 32'd0);
            chk("rst_upc", 32'(oUopAddr), 32'd0);
        end
        iFetchAck = 1'b0;
        @(posedge iClock); #1;
        iReset = 1'b1;
        @(negedge iClock);
        chk_ctl("rst_cycle1", 0, 0, 0, 0, 0);
        @(posedge iClock); #1;

        // One-byte op: 3-cycle instruction.
        fetch(8'h00, 0);
        exec_cyc("onebyte", 0, 8'd0, 1, 1, 0, 1);

        for (int i = 0; i < 12; i++) begin
            rom[40]   = {tbl[i].code, 9'h011};
            rom[41]   = {4'd2, 9'h022};
            iZeroFlag = tbl[i].z;
            fetch(8'h40, i % 3);
            exec_cyc($sformatf("tbl%0d", i), 0, 8'd40, tbl[i].v, tbl[i].pc, tbl[i].fu, tbl[i].done);
            if (!tbl[i].done) exec_cyc($sformatf("tbl%0d_eof", i), 0, 8'd41, 1, 0, 0, 1);
        end

        // LD r,n with a two-cycle stall on the second uop.
        fetch(8'h06, 0);
        exec_cyc("ld_23", 0, 8'd23, 1, 1, 0, 0);
        exec_cyc("ld_stall", 1, 8'd24, 0, 0, 0, 0);
        exec_cyc("ld_stall", 1, 8'd24, 0, 0, 0, 0);
        exec_cyc("ld_24", 0, 8'd24, 1, 1, 0, 0);
        exec_cyc("ld_25", 0, 8'd25, 1, 0, 0, 1);

        // JR NZ: Z=1 exits early at 19, Z=0 walks the whole flow.
        iZeroFlag = 1'b1;
        fetch(8'h20, 0);
        exec_cyc("jrnz1_17", 0, 8'd17, 1, 1, 0, 0);
        exec_cyc("jrnz1_18", 0, 8'd18, 1, 1, 0, 0);
        exec_cyc("jrnz1_19", 0, 8'd19, 0, 1, 0, 1);
        iZeroFlag = 1'b0;
        fetch(8'h20, 1);
        exec_cyc("jrnz0_17", 0, 8'd17, 1, 1, 0, 0);
        exec_cyc("jrnz0_18", 0, 8'd18, 1, 1, 0, 0);
        exec_cyc("jrnz0_19", 0, 8'd19, 1, 1, 0, 0);
        exec_cyc("jrnz0_20", 0, 8'd20, 1, 1, 0, 0);
        exec_cyc("jrnz0_21", 0, 8'd21, 1, 1, 0, 0);
        exec_cyc("jrnz0_22", 0, 8'd22, 1, 0, 0, 1);

        // CB prefix re-dispatch through the CB table.
        fetch(8'hCB, 0);
        exec_cyc("cb_13", 0, 8'd13, 1, 0, 0, 0);
        exec_cyc("cb_14", 0, 8'd14, 1, 0, 0, 0);
        exec_cyc("cb_stall", 1, 8'd15, 0, 0, 0, 0);
        exec_cyc("cb_15", 0, 8'd15, 1, 1, 0, 0);
        fetch(8'h7C, 0);
        exec_cyc("cb_16", 0, 8'd16, 1, 0, 1, 1);

        // Runaway flow: watchdog fires on the 32nd uop, error is sticky.
        fetch(8'h80, 0);
        for (int i = 0; i < MAXF; i++)
            exec_cyc("wdog", 0, 8'(200 + i), 1, 0, 0, i == MAXF - 1);
        exp_err = 1'b1;
        fetch(8'h06, 0);
        exec_cyc("err_ld_23", 0, 8'd23, 1, 1, 0, 0);
        exec_cyc("err_ld_24", 0, 8'd24, 1, 1, 0, 0);
        exec_cyc("err_ld_25", 0, 8'd25, 1, 0, 0, 1);

        // Reset while a CB re-fetch is pending clears the error and the CB page.
        fetch(8'hCB, 0);
        exec_cyc("cbr_13", 0, 8'd13, 1, 0, 0, 0);
        exec_cyc("cbr_14", 0, 8'd14, 1, 0, 0, 0);
        exec_cyc("cbr_15", 0, 8'd15, 1, 1, 0, 0);
        iReset  = 1'b0;
        exp_err = 1'b0;
        #1;
        chk_ctl("rst_mid", 0, 0, 0, 0, 0);
        chk("rst_mid_mop", 32'(oMop), 32'd0);
        chk("rst_mid_upc", 32'(oUopAddr), 32'd0);
        @(posedge iClock); #1;
        iReset = 1'b1;
        @(negedge iClock);
        chk_ctl("rst_mid_cycle1", 0, 0, 0, 0, 0);
        @(posedge iClock); #1;
        fetch(8'h7C, 0);
        exec_cyc("rst_nocb", 0, 8'd100, 1, 0, 0, 1);

        // Random microcode and tables against the reference model.
        for (int a = 0; a < 256; a++) begin
            rom[a] = {4'($urandom_range(0, 15)), 9'($urandom)};
            if ($urandom_range(0, 9) == 0) rom[a][8:4] = 5'h0E;
            lut[a]   = 8'($urandom);
            cblut[a] = 8'($urandom);
        end
        cbp = 1'b0;
        for (int t = 0; t < 200; t++) begin
            iZeroFlag = 1'($urandom);
            b = 8'($urandom);
            build(cbp ? cblut[b] : lut[b], iZeroFlag);
            fetch(b, $urandom_range(0, 2));
            run_exec();
            cbp = cb_next;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
